// File: rtl/amo_arbiter_if.sv
// Requester-side bundle of the atomic-memory arbiter: per-hart request lanes in,
// one-hot grant / completion pulses and shared response data out.
interface amo_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
);
  // Handshake: a requester raises i_req[n] with stable op/addr/wdata and holds it
  // until o_gnt[n] pulses (the request is accepted that cycle); exactly one cycle
  // later o_rvalid[n] pulses with o_rdata, which is not back-pressurable.
  logic [NUM_REQ-1:0]        i_req;
  logic [3*NUM_REQ-1:0]      i_op;
  logic [ADDR_W*NUM_REQ-1:0] i_addr;
  logic [DATA_W*NUM_REQ-1:0] i_wdata;
  logic [NUM_REQ-1:0]        o_gnt;
  logic [NUM_REQ-1:0]        o_rvalid;
  logic [DATA_W-1:0]         o_rdata;

  modport master (
    output i_req, i_op, i_addr, i_wdata,
    input  o_gnt, o_rvalid, o_rdata
  );

  modport slave (
    input  i_req, i_op, i_addr, i_wdata,
    output o_gnt, o_rvalid, o_rdata
  );
endinterface

// File: rtl/amo_arbiter.sv
// Round-robin arbiter that serialises LOAD/STORE/LR/SC/AMO requests from several
// harts onto one data-memory port and drives the shared reservation set.
module amo_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  amo_arbiter_if.slave               bus,
  output logic                       o_mem_en,
  output logic                       o_mem_we,
  output logic [ADDR_W-1:0]          o_mem_addr,
  output logic [DATA_W-1:0]          o_mem_wdata,
  input  logic [DATA_W-1:0]          i_mem_rdata,
  output logic [ADDR_W-1:0]          o_rs_addr,
  output logic                       o_rs_store_op,
  output logic                       o_rs_store_cond_op,
  output logic                       o_rs_load_reserved_op,
  output logic [$clog2(NUM_REQ)-1:0] o_rs_hartid,
  input  logic                       i_rs_sc_success,
  output logic [1:0]                 o_state
);
  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_LR    = 3'd2;
  localparam logic [2:0] OP_SC    = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_ADD   = 3'd5;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_COMPLETE = 2'd2} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_idx;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [IDX_W-1:0]    w_win;
  logic [IDX_W-1:0]    w_cand;
  logic                w_found;
  logic [DATA_W-1:0]   w_sum;

  assign o_state = r_state;

  // Search starts one past the last winner; index arithmetic wraps because NUM_REQ is a power of two.
  always_comb begin
    w_win   = r_last;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = r_last + IDX_W'(i);
      if (!w_found && bus.i_req[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_found) w_next = S_ISSUE;
      S_ISSUE:    w_next = S_COMPLETE;
      S_COMPLETE: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_idx   <= '0;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && w_found) begin
      r_last  <= w_win;
      r_idx   <= w_win;
      r_op    <= bus.i_op[int'(w_win)*3 +: 3];
      r_addr  <= bus.i_addr[int'(w_win)*ADDR_W +: ADDR_W];
      r_wdata <= bus.i_wdata[int'(w_win)*DATA_W +: DATA_W];
    end
  end

  // Every output is decoded from the state, so an asynchronous reset zeroes them at once.
  always_comb begin
    o_mem_en              = 1'b0;
    o_mem_we              = 1'b0;
    o_mem_addr            = '0;
    o_mem_wdata           = '0;
    o_rs_addr             = '0;
    o_rs_hartid           = '0;
    o_rs_store_op         = 1'b0;
    o_rs_store_cond_op    = 1'b0;
    o_rs_load_reserved_op = 1'b0;
    bus.o_gnt             = '0;
    bus.o_rvalid          = '0;
    bus.o_rdata           = '0;
    w_sum                 = i_mem_rdata + r_wdata;
    case (r_state)
      S_ISSUE: begin
        bus.o_gnt[r_idx] = 1'b1;
        o_rs_addr        = r_addr;
        o_rs_hartid      = r_idx;
        case (r_op)
          OP_LOAD, OP_LR, OP_SWAP, OP_ADD: begin
            o_mem_en              = 1'b1;
            o_mem_addr            = r_addr;
            o_rs_load_reserved_op = (r_op == OP_LR);
          end
          OP_STORE: begin
            o_mem_en      = 1'b1;
            o_mem_we      = 1'b1;
            o_mem_addr    = r_addr;
            o_mem_wdata   = r_wdata;
            o_rs_store_op = 1'b1;
          end
          OP_SC:   o_rs_store_cond_op = 1'b1;
          default: ;
        endcase
      end
      S_COMPLETE: begin
        bus.o_rvalid[r_idx] = 1'b1;
        o_rs_addr           = r_addr;
        o_rs_hartid         = r_idx;
        case (r_op)
          OP_LOAD, OP_LR: bus.o_rdata = i_mem_rdata;
          OP_SC: begin
            if (i_rs_sc_success) begin
              o_mem_en    = 1'b1;
              o_mem_we    = 1'b1;
              o_mem_addr  = r_addr;
              o_mem_wdata = r_wdata;
            end
            bus.o_rdata = {{(DATA_W-1){1'b0}}, ~i_rs_sc_success};
          end
          OP_SWAP, OP_ADD: begin
            o_mem_en      = 1'b1;
            o_mem_we      = 1'b1;
            o_mem_addr    = r_addr;
            o_mem_wdata   = (r_op == OP_ADD) ? w_sum : r_wdata;
            o_rs_store_op = 1'b1;
            bus.o_rdata   = i_mem_rdata;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_amo_arbiter.sv
// Directed bench for amo_arbiter: behavioural memory and reservation-set models,
// a response scoreboard fed by the driver and drained by a separate monitor.
module tb_amo_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int EW      = NUM_REQ + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              o_mem_en, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr, o_rs_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata = '0;
  logic              o_rs_store_op, o_rs_store_cond_op, o_rs_load_reserved_op;
  logic [1:0]        o_rs_hartid;
  logic              i_rs_sc_success = 1'b0;
  logic [1:0]        o_state;

  logic [DATA_W-1:0] mem [0:4095];
  logic              sc_verdict = 1'b1;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  logic [EW-1:0]     exp_q[$];

  logic [4:0]        g_strb, c_strb;
  logic [ADDR_W-1:0] g_rsaddr;
  logic [1:0]        g_hart;

  amo_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  amo_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_rs_addr(o_rs_addr), .o_rs_store_op(o_rs_store_op),
    .o_rs_store_cond_op(o_rs_store_cond_op),
    .o_rs_load_reserved_op(o_rs_load_reserved_op),
    .o_rs_hartid(o_rs_hartid), .i_rs_sc_success(i_rs_sc_success),
    .o_state(o_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory and reservation-set models
  always @(posedge clk) begin
    if (o_mem_en && o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata     <= (o_mem_en && !o_mem_we) ? mem[o_mem_addr] : '0;
    i_rs_sc_success <= o_rs_store_cond_op & sc_verdict;
  end

  function automatic logic [4:0] strobes();
    return {o_mem_en, o_mem_we, o_rs_load_reserved_op, o_rs_store_op, o_rs_store_cond_op};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (|bus.o_rvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", {bus.o_rvalid, bus.o_rdata}, '0);
        end else begin
          automatic logic [EW-1:0] e = exp_q.pop_front();
          check("response", {bus.o_rvalid, bus.o_rdata}, e);
        end
      end else begin
        check("rdata_idle", bus.o_rdata, '0);
      end
    end
  end

  task automatic expect_rsp(input int idx, input logic [DATA_W-1:0] d);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << idx;
    exp_q.push_back({oh, d});
  endtask

  task automatic set_lane(input int idx, input logic [2:0] op, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd);
    bus.i_op[idx*3 +: 3]              = op;
    bus.i_addr[idx*ADDR_W +: ADDR_W]  = a;
    bus.i_wdata[idx*DATA_W +: DATA_W] = wd;
    bus.i_req[idx]                    = 1'b1;
  endtask

  task automatic wait_gnt(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      if (|bus.o_gnt) ok = 1'b1;
    end
    if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  // driver: one complete operation, returns at the negedge after COMPLETE
  task automatic run_op(input int idx, input logic [2:0] op, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_d);
    bit ok;
    expect_rsp(idx, exp_d);
    set_lane(idx, op, a, wd);
    wait_gnt("op_gnt", ok);
    check("op_gnt_onehot", bus.o_gnt, NUM_REQ'(1) << idx);
    g_strb   = strobes();
    g_rsaddr = o_rs_addr;
    g_hart   = o_rs_hartid;
    bus.i_req[idx] = 1'b0;
    @(negedge clk);
    c_strb = strobes();
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int last_cyc;
    bus.i_req = '0; bus.i_op = '0; bus.i_addr = '0; bus.i_wdata = '0;

    // reset state with all four harts already requesting STOREs
    for (int i = 0; i < 4; i++) set_lane(i, 3'd1, ADDR_W'(12'h100 + i), 32'h1000 + i);
    #12;
    check("rst_gnt", bus.o_gnt, '0);
    check("rst_rvalid", bus.o_rvalid, '0);
    check("rst_rdata", bus.o_rdata, '0);
    check("rst_mem", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata}, '0);
    check("rst_rs", {strobes(), o_rs_addr, o_rs_hartid}, '0);
    check("rst_state", o_state, 2'd0);

    // continuous STOREs: round-robin 0,1,2,3,0 every 3 cycles
    for (int k = 0; k < 5; k++) expect_rsp(k % 4, '0);
    @(negedge clk);
    reset = 1'b1;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr_gnt", ok);
      check("rr_order", bus.o_gnt, NUM_REQ'(1) << (k % 4));
      check("rr_store_strobe", strobes(), 5'b11010);
      if (k > 0) check("rr_spacing", cyc - last_cyc, 3);
      last_cyc = cyc;
      if (k == 4) bus.i_req = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check("rr_mem", mem[12'h100 + i], 32'h1000 + i);

    // single LOAD from req1, cycle-exact timing
    mem[12'h010] <= 32'hDEADBEEF;
    expect_rsp(1, 32'hDEADBEEF);
    set_lane(1, 3'd0, 12'h010, '0);
    @(negedge clk);
    check("load_gnt_t1", bus.o_gnt, 4'b0010);
    check("load_mem_rd", {o_mem_en, o_mem_we, o_mem_addr}, {2'b10, 12'h010});
    bus.i_req = '0;
    @(negedge clk);
    check("load_rvalid_t2", bus.o_rvalid, 4'b0010);
    @(negedge clk);

    // LR / SC by req2
    mem[12'h020] <= 32'h11;
    run_op(2, 3'd2, 12'h020, '0, 32'h11);
    check("lr_strobe", g_strb, 5'b10100);
    check("lr_rs", {g_rsaddr, g_hart}, {12'h020, 2'd2});
    sc_verdict = 1'b1;
    run_op(2, 3'd3, 12'h020, 32'd5, 32'd0);
    check("sc_issue_strobe", g_strb, 5'b00001);
    check("sc_ok_write", c_strb, 5'b11000);
    check("sc_ok_mem", mem[12'h020], 32'd5);
    sc_verdict = 1'b0;
    run_op(2, 3'd3, 12'h020, 32'd9, 32'd1);
    check("sc_fail_nowrite", c_strb, 5'b00000);
    check("sc_fail_mem", mem[12'h020], 32'd5);

    // AMOADD wraps, AMOSWAP, NOP
    mem[12'h030] <= 32'hFFFFFFFF;
    run_op(0, 3'd5, 12'h030, 32'd2, 32'hFFFFFFFF);
    check("add_issue_strobe", g_strb, 5'b10000);
    check("add_cpl_strobe", c_strb, 5'b11010);
    check("add_mem", mem[12'h030], 32'h00000001);
    mem[12'h050] <= 32'h1234;
    run_op(3, 3'd4, 12'h050, 32'hCAFE, 32'h1234);
    check("swap_mem", mem[12'h050], 32'hCAFE);
    run_op(1, 3'd6, 12'h060, 32'h77, 32'd0);
    check("nop_strobe", {g_strb, c_strb}, 10'd0);

    // reset during COMPLETE of a STORE aborts it; req0 wins first afterwards
    set_lane(0, 3'd1, 12'h040, 32'h4444);
    wait_gnt("abort_gnt", ok);
    bus.i_req = '0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_rvalid", bus.o_rvalid, '0);
    check("abort_mem", {o_mem_en, o_mem_we, o_mem_wdata}, '0);
    check("abort_rs", strobes(), '0);
    check("abort_state", o_state, 2'd0);
    set_lane(0, 3'd0, 12'h010, '0);
    mem[12'h011] <= 32'h5A5A;
    set_lane(1, 3'd0, 12'h011, '0);
    @(negedge clk);
    @(negedge clk);
    expect_rsp(0, 32'hDEADBEEF);
    expect_rsp(1, 32'h5A5A);
    reset = 1'b1;
    wait_gnt("post_rst_gnt0", ok);
    check("post_rst_first", bus.o_gnt, 4'b0001);
    bus.i_req[0] = 1'b0;
    wait_gnt("post_rst_gnt1", ok);
    check("post_rst_second", bus.o_gnt, 4'b0010);
    bus.i_req[1] = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
